// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: instruction operands, writeback
// commit, branch resolution, and the interlock/status outputs.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 5
`define OP_ADD   5'd0
`define OP_AND   5'd1
`define OP_MOVI  5'd2
`define OP_BRN   5'd3
`define OP_BRZ   5'd4
`define OP_BRP   5'd5
`define OP_BRNZ  5'd6
`define OP_BRNP  5'd7
`define OP_BRZP  5'd8
`define OP_BRNZP 5'd9
`define OP_JMP   5'd10
`define OP_JSR   5'd11
`define OP_JSRR  5'd12
`endif

interface hazard_scoreboard_if #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 16
);
  logic                     I_LOCK;
  logic                     I_Valid;
  logic [`OPCODE_WIDTH-1:0] I_Opcode;
  logic [3:0]               I_Src1Idx;
  logic [3:0]               I_Src2Idx;
  logic                     I_Src1Used;
  logic                     I_Src2Used;
  logic [3:0]               I_DestIdx;
  logic                     I_DestUsed;
  logic                     I_WBValid;
  logic [3:0]               I_WBRegIdx;
  logic                     I_BranchDone;
  logic                     O_DepStall;
  logic                     O_FetchStall;
  logic                     O_Issue;
  logic [NUM_REGS-1:0]      O_BusyMask;
  logic [CNT_WIDTH-1:0]     O_StallCount;

  // Pipeline side: drives decode/writeback/branch info, consumes interlocks.
  modport master (
    output I_LOCK, I_Valid, I_Opcode, I_Src1Idx, I_Src2Idx, I_Src1Used,
           I_Src2Used, I_DestIdx, I_DestUsed, I_WBValid, I_WBRegIdx,
           I_BranchDone,
    input  O_DepStall, O_FetchStall, O_Issue, O_BusyMask, O_StallCount
  );

  // Scoreboard side.
  modport slave (
    input  I_LOCK, I_Valid, I_Opcode, I_Src1Idx, I_Src2Idx, I_Src1Used,
           I_Src2Used, I_DestIdx, I_DestUsed, I_WBValid, I_WBRegIdx,
           I_BranchDone,
    output O_DepStall, O_FetchStall, O_Issue, O_BusyMask, O_StallCount
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock controller: tracks registers with writes in flight,
// stalls dependent instructions, holds fetch while a branch/jump resolves,
// and keeps a saturating stall-cycle counter. State updates on negedge.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 5
`define OP_ADD   5'd0
`define OP_AND   5'd1
`define OP_MOVI  5'd2
`define OP_BRN   5'd3
`define OP_BRZ   5'd4
`define OP_BRP   5'd5
`define OP_BRNZ  5'd6
`define OP_BRNP  5'd7
`define OP_BRZP  5'd8
`define OP_BRNZP 5'd9
`define OP_JMP   5'd10
`define OP_JSR   5'd11
`define OP_JSRR  5'd12
`endif

module hazard_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 16
) (
  input logic                I_CLOCK,
  input logic                I_RESET,
  hazard_scoreboard_if.slave bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  state_t               state_q;
  logic                 fetch_stall_q;
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  set_vec;
  logic [NUM_REGS-1:0]  clr_vec;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic                 dep_stall;
  logic                 issue;
  logic                 stall_cycle;

  // Any control transfer blocks fetch until the memory stage resolves it.
  function automatic logic is_ctrl_xfer(input logic [`OPCODE_WIDTH-1:0] op);
    case (op)
      `OP_BRN, `OP_BRZ, `OP_BRP, `OP_BRNZ, `OP_BRNP, `OP_BRZP, `OP_BRNZP,
      `OP_JMP, `OP_JSR, `OP_JSRR: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    return c + CNT_WIDTH'(1);
  endfunction

  // Hazard detection against registered busy bits only (no writeback bypass).
  always_comb begin
    dep_stall = bus.I_LOCK & bus.I_Valid &
                ((bus.I_Src1Used & busy_q[bus.I_Src1Idx]) |
                 (bus.I_Src2Used & busy_q[bus.I_Src2Idx]) |
                 (bus.I_DestUsed & busy_q[bus.I_DestIdx]));
    issue       = bus.I_LOCK & bus.I_Valid & ~dep_stall & (state_q == IDLE);
    stall_cycle = bus.I_LOCK & bus.I_Valid & ~issue;
    set_vec = '0;
    clr_vec = '0;
    if (issue && bus.I_DestUsed) set_vec[bus.I_DestIdx] = 1'b1;
    if (bus.I_WBValid)           clr_vec[bus.I_WBRegIdx] = 1'b1;
  end

  // Busy mask and stall counter; a set on the same register as a clear wins.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else if (bus.I_LOCK) begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
      if (stall_cycle) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // Branch-wait FSM with registered fetch stall.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state_q       <= IDLE;
      fetch_stall_q <= 1'b0;
    end else if (bus.I_LOCK) begin
      case (state_q)
        IDLE: begin
          if (issue && is_ctrl_xfer(bus.I_Opcode)) begin
            state_q       <= BR_WAIT;
            fetch_stall_q <= 1'b1;
          end
        end
        BR_WAIT: begin
          if (bus.I_BranchDone) begin
            state_q       <= IDLE;
            fetch_stall_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          fetch_stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.O_DepStall   = dep_stall;
  assign bus.O_Issue      = issue;
  assign bus.O_FetchStall = fetch_stall_q;
  assign bus.O_BusyMask   = busy_q;
  assign bus.O_StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: a table of per-cycle vectors with
// hand-derived expectations routed through an expectation queue, plus
// hand-written sequences for lock hold and counter saturation.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 5
`define OP_ADD   5'd0
`define OP_AND   5'd1
`define OP_MOVI  5'd2
`define OP_BRN   5'd3
`define OP_BRZ   5'd4
`define OP_BRP   5'd5
`define OP_BRNZ  5'd6
`define OP_BRNP  5'd7
`define OP_BRZP  5'd8
`define OP_BRNZP 5'd9
`define OP_JMP   5'd10
`define OP_JSR   5'd11
`define OP_JSRR  5'd12
`endif

module tb_hazard_scoreboard;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.NUM_REGS(16), .CNT_WIDTH(16)) bus ();

  hazard_scoreboard #(.NUM_REGS(16), .CNT_WIDTH(16)) dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, lock, valid;
    logic [4:0]  op;
    logic [3:0]  s1;
    logic        s1u;
    logic [3:0]  s2;
    logic        s2u;
    logic [3:0]  d;
    logic        du;
    logic        wb;
    logic [3:0]  wbi;
    logic        bd;
    logic        dep, iss;
    logic [15:0] mask;
    logic        fs;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          tag;
    logic        dep, iss;
    logic [15:0] mask;
    logic        fs;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[22];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mkv(input int r, input int lk, input int vl, input logic [4:0] op,
                               input int s1, input int s1u, input int s2, input int s2u,
                               input int d, input int du, input int wb, input int wbi,
                               input int bd, input int dep, input int iss, input int mask,
                               input int fs, input int cnt);
    vec_t v;
    v.rst = 1'(r);   v.lock = 1'(lk); v.valid = 1'(vl); v.op = op;
    v.s1  = 4'(s1);  v.s1u  = 1'(s1u); v.s2 = 4'(s2);   v.s2u = 1'(s2u);
    v.d   = 4'(d);   v.du   = 1'(du);  v.wb = 1'(wb);   v.wbi = 4'(wbi);
    v.bd  = 1'(bd);  v.dep  = 1'(dep); v.iss = 1'(iss);
    v.mask = 16'(mask); v.fs = 1'(fs); v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    bus.I_LOCK       = v.lock;
    bus.I_Valid      = v.valid;
    bus.I_Opcode     = v.op;
    bus.I_Src1Idx    = v.s1;
    bus.I_Src1Used   = v.s1u;
    bus.I_Src2Idx    = v.s2;
    bus.I_Src2Used   = v.s2u;
    bus.I_DestIdx    = v.d;
    bus.I_DestUsed   = v.du;
    bus.I_WBValid    = v.wb;
    bus.I_WBRegIdx   = v.wbi;
    bus.I_BranchDone = v.bd;
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, advance past the update edge.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    drive(v);
    e.tag = tag; e.dep = v.dep; e.iss = v.iss; e.mask = v.mask; e.fs = v.fs; e.cnt = v.cnt;
    exp_q.push_back(e);
    @(posedge clk);
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d.queue", tag), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d.dep", e.tag),   32'(bus.O_DepStall),   32'(e.dep));
      chk($sformatf("v%0d.issue", e.tag), 32'(bus.O_Issue),      32'(e.iss));
      chk($sformatf("v%0d.mask", e.tag),  32'(bus.O_BusyMask),   32'(e.mask));
      chk($sformatf("v%0d.fstall", e.tag),32'(bus.O_FetchStall), 32'(e.fs));
      chk($sformatf("v%0d.count", e.tag), 32'(bus.O_StallCount), 32'(e.cnt));
    end
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive(mkv(1,1,0,`OP_ADD,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_c;
    //          rst lk vl op        s1 u s2 u d  u wb wi bd  dep iss mask     fs cnt
    vecs[0]  = mkv(0,1,0,`OP_ADD,   0,0,0,0,0,0,0,0,0,  0,0,16'h0000,0,0);
    vecs[1]  = mkv(0,1,1,`OP_ADD,   2,1,3,1,1,1,0,0,0,  0,1,16'h0000,0,0);
    vecs[2]  = mkv(0,1,1,`OP_ADD,   1,1,5,1,4,1,0,0,0,  1,0,16'h0002,0,0);
    vecs[3]  = mkv(0,1,1,`OP_ADD,   1,1,5,1,4,1,1,1,0,  1,0,16'h0002,0,1);
    vecs[4]  = mkv(0,1,1,`OP_ADD,   1,1,5,1,4,1,0,0,0,  0,1,16'h0000,0,2);
    vecs[5]  = mkv(0,1,1,`OP_ADD,   2,1,2,1,3,1,0,0,0,  0,1,16'h0010,0,2);
    vecs[6]  = mkv(0,1,1,`OP_MOVI,  0,0,0,0,3,1,0,0,0,  1,0,16'h0018,0,2);
    vecs[7]  = mkv(0,1,1,`OP_MOVI,  0,0,0,0,3,1,1,3,0,  1,0,16'h0018,0,3);
    vecs[8]  = mkv(0,1,1,`OP_MOVI,  0,0,0,0,3,1,0,0,0,  0,1,16'h0010,0,4);
    vecs[9]  = mkv(0,1,1,`OP_ADD,   2,1,5,1,6,1,1,6,0,  0,1,16'h0018,0,4);
    vecs[10] = mkv(0,1,0,`OP_ADD,   0,0,0,0,0,0,1,4,0,  0,0,16'h0058,0,4);
    vecs[11] = mkv(0,1,1,`OP_BRZ,   0,0,0,0,0,0,0,0,0,  0,1,16'h0048,0,4);
    vecs[12] = mkv(0,1,1,`OP_ADD,   2,1,5,1,9,1,0,0,0,  0,0,16'h0048,1,4);
    vecs[13] = mkv(0,1,1,`OP_ADD,   2,1,5,1,9,1,0,0,0,  0,0,16'h0048,1,5);
    vecs[14] = mkv(0,1,1,`OP_ADD,   2,1,5,1,9,1,0,0,0,  0,0,16'h0048,1,6);
    vecs[15] = mkv(0,1,1,`OP_ADD,   2,1,5,1,9,1,0,0,1,  0,0,16'h0048,1,7);
    vecs[16] = mkv(0,1,1,`OP_ADD,   2,1,5,1,9,1,0,0,0,  0,1,16'h0048,0,8);
    vecs[17] = mkv(0,1,1,`OP_JSRR,  2,1,0,0,7,1,0,0,0,  0,1,16'h0248,0,8);
    vecs[18] = mkv(0,1,0,`OP_ADD,   0,0,0,0,0,0,0,0,0,  0,0,16'h02C8,1,8);
    vecs[19] = mkv(1,1,0,`OP_ADD,   0,0,0,0,0,0,0,0,0,  0,0,16'h02C8,1,8);
    vecs[20] = mkv(0,1,0,`OP_ADD,   0,0,0,0,0,0,0,0,1,  0,0,16'h0000,0,0);
    vecs[21] = mkv(0,1,0,`OP_ADD,   0,0,0,0,0,0,0,0,0,  0,0,16'h0000,0,0);

    reset_pulse();
    for (int i = 0; i < 22; i++) apply(vecs[i], i);

    // Lock hold: writeback of R1 while unlocked is lost, nothing moves.
    apply(mkv(0,1,1,`OP_ADD, 2,1,3,1,1,1,0,0,0, 0,1,16'h0000,0,0), 100);
    for (int i = 0; i < 5; i++)
      apply(mkv(0,0,1,`OP_ADD, 1,1,5,1,4,1,1,1,0, 0,0,16'h0002,0,0), 101 + i);
    apply(mkv(0,1,1,`OP_ADD, 1,1,5,1,4,1,0,0,0, 1,0,16'h0002,0,0), 106);
    apply(mkv(0,1,0,`OP_ADD, 0,0,0,0,0,0,0,0,0, 0,0,16'h0002,0,1), 107);

    // Saturation: hold a dependent instruction for 70000 stall cycles.
    reset_pulse();
    apply(mkv(0,1,1,`OP_ADD, 2,1,3,1,1,1,0,0,0, 0,1,16'h0000,0,0), 200);
    drive(mkv(0,1,1,`OP_ADD, 1,1,5,1,4,1,0,0,0, 0,0,0,0,0));
    for (int k = 0; k <= 70000; k++) begin
      @(posedge clk);
      if (k == 0 || k == 3 || k == 65534 || k == 65535 || k == 70000) begin
        exp_c = (k < 65535) ? k : 65535;
        chk($sformatf("sat.count@%0d", k), 32'(bus.O_StallCount), 32'(exp_c));
        chk($sformatf("sat.dep@%0d", k), 32'(bus.O_DepStall), 32'd1);
      end
      @(negedge clk);
      #1;
    end

    chk("queue.empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
